i2c_ack_monitor: RTL and testbench
==================================

# i2c_ack_monitor

Open-drain pad stage and bus monitor that sits directly downstream of the AK4619 I2C init transmitter. It converts the transmitter's push-pull `scl`/`sda_out` into active-low pad output enables. It samples the real SDA pad to decode START/STOP, data bytes and the slave ACK bit, and reports per-transaction success so the codec bring-up logic can tell whether the configuration write landed.

## Interface
- `N_BYTES`, default 16'h17: number of bytes (address byte included) in one complete, correct transaction.
- `SYNC_STAGES`, default 2: synchronizer depth on `sda_pin_in`. Legal range is 2..4.

Ports:
- `clk`  in  1: same 2x-I2C clock that drives the transmitter. This is the only clock.
- `rst`  in  1: synchronous, active-high reset.
- `scl_in`  in  1: transmitter `scl`.
- `sda_drv`  in  1: transmitter `sda_out`.
- `sda_pin_in`  in  1: SDA pad input. Asynchronous.
- `scl_oe`  out  1: 1 pulls SCL low.
- `sda_oe`  out  1: 1 pulls SDA low.
- `start_det`  out  1: one-cycle pulse on a START or repeated START.
- `stop_det`  out  1: one-cycle pulse on a STOP.
- `ack_ok`  out  1: one-cycle pulse when the 9th bit is sampled low.
- `nack`  out  1: one-cycle pulse when the 9th bit is sampled high.
- `txn_done`  out  1: one-cycle pulse on a STOP that ends an active transaction.
- `txn_ok`  out  1: sticky result of the last completed transaction.
- `busy`  out  1: high between START and STOP.
- `last_byte`  out  8: most recent complete data byte seen on SDA.
- `byte_count`  out  16: bytes completed in the current or last transaction.
- `nack_count`  out  8: total NACKs since reset. Saturates at 255.

## Operation
**Pad conversion (combinational)**
- `scl_oe = ~scl_in & ~rst`.
- `sda_oe = ~sda_drv & ~rst`.

**Alignment**
- `sda_s`: `sda_pin_in` passed through `SYNC_STAGES` flops.
- `scl_s`: `scl_in` delayed by the same `SYNC_STAGES` flops, so the two stay aligned.
- One further register holds `scl_p` and `sda_p`, the previous values of `scl_s` and `sda_s`.

**Event decode**, evaluated every cycle:
- START: `scl_s & scl_p & sda_p & ~sda_s`.
- STOP: `scl_s & scl_p & ~sda_p & sda_s`.
- SCL rise: `scl_s & ~scl_p`.
- These three events are mutually exclusive by construction, so no priority rule is needed.

**State machine: IDLE, ACTIVE.**
- IDLE + START → ACTIVE. Actions: `bit_cnt` = 0, `byte_count` = 0, clear `txn_nack`, pulse `start_det`.
- IDLE + STOP: pulse `stop_det` only. `txn_done` is not pulsed and `txn_ok` is unchanged.
- IDLE + SCL rise: ignored.
- ACTIVE + SCL rise with `bit_cnt` < 8: shift `sda_s` into the shift register MSB-first, then `bit_cnt`++.
- ACTIVE + SCL rise with `bit_cnt` == 8 (ACK bit):
  - Load `last_byte` from the shift register and increment `byte_count`.
  - If `sda_s` = 0: pulse `ack_ok`.
  - If `sda_s` = 1: pulse `nack`, set `txn_nack`, increment `nack_count` (saturating).
  - Set `bit_cnt` = 0.
- ACTIVE + START (repeated START): `bit_cnt` = 0. `byte_count` and `txn_nack` are kept. Pulse `start_det`.
- ACTIVE + STOP → IDLE.
  - Pulse `stop_det` and `txn_done`.
  - `txn_ok <= ~txn_nack & (byte_count == N_BYTES) & (bit_cnt == 0)`.
  - A STOP in the middle of a byte therefore gives `txn_ok` = 0.
- `busy` = (state == ACTIVE).

**Width rules**
- `byte_count` wraps modulo 2^16.
- `bit_cnt` is 4 bits wide and never exceeds 8.

**Reset**
- All outputs and counters go to 0; state goes to IDLE.
- Synchronizer and delay flops reset to 1, which represents an idle, released bus.
- A reset asserted mid-transaction abandons the transaction with no `txn_done` pulse.
- After reset the block needs a fresh START before it counts anything.

## Timing
- `scl_oe` and `sda_oe` have zero latency (combinational).
- A pad or `scl_in` change sampled at edge n produces its pulse in the cycle after edge n+`SYNC_STAGES`+1.
- All pulse outputs are exactly one cycle wide.
- `last_byte`, `byte_count`, `nack_count` and `txn_ok` update on the same edge as the corresponding pulse.

## Structure
- Shared package `ak4619_i2c_pkg`:
  - state enum `i2cmon_state_t`
  - `I2C_ACK_BIT` = 4'd8
  - `NACK_CNT_MAX` = 8'hFF
- One sub-module, `bit_sync`: a parameterized N-flop synchronizer with a reset value parameter. It is instantiated for `sda_pin_in` and for the `scl_in` delay.

## Test plan
- **Good transaction.** START, bytes 0x20 plus 0x16 further bytes, each ACKed (pin low on bit 9), then STOP.
  - Expect 0x17 `ack_ok` pulses and `byte_count` = 0x17.
  - Expect `txn_done` with `txn_ok` = 1 and `nack_count` = 0.
- **NACK on address.** START, 0x20 with the pin high on bit 9, then STOP.
  - Expect one `nack` pulse, `nack_count` = 1, `txn_ok` = 0, `last_byte` = 0x20.
- **Short transaction.** STOP after 5 ACKed bytes.
  - Expect `byte_count` = 5 and `txn_ok` = 0.
- **Mid-byte STOP and stray events.**
  - STOP after 3 bits of byte 0x17: expect `txn_ok` = 0.
  - STOP while IDLE: expect `stop_det` only, with no `txn_done`.
- **Reset and saturation.**
  - Assert `rst` mid-byte: expect `busy` = 0, `scl_oe` = `sda_oe` = 0, all counters 0, and no `txn_done` pulse.
  - Run 300 NACK transactions: expect `nack_count` = 255.
- **Latency and pad conversion.**
  - Drive START with `SYNC_STAGES` = 3: expect `start_det` exactly 4 cycles after the SDA fall.
  - With `sda_drv` = 0 and `rst` = 0: expect `sda_oe` = 1 in the same cycle.

Source files
------------

// File: rtl/ak4619_i2c_pkg.sv
// Shared types and constants for the AK4619 I2C init path and its bus monitor.
package ak4619_i2c_pkg;

  typedef enum logic {
    IDLE,
    ACTIVE
  } i2cmon_state_t;

  localparam logic [3:0] I2C_ACK_BIT  = 4'd8;
  localparam logic [7:0] NACK_CNT_MAX = 8'hFF;

endpackage

// File: rtl/i2c_ack_monitor_bit_sync.sv
// N-flop single-bit synchronizer / delay line with a configurable reset value.
module bit_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk) begin
    if (rst) sync_q <= {STAGES{RST_VAL}};
    else     sync_q <= sync_d;
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/i2c_ack_monitor.sv
// Open-drain pad stage plus SDA/SCL bus monitor: decodes START/STOP, bytes and
// the slave ACK bit, and reports whether each write transaction completed cleanly.
module i2c_ack_monitor
  import ak4619_i2c_pkg::*;
#(
  parameter logic [15:0] N_BYTES     = 16'h17,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_in,
  input  logic        sda_drv,
  input  logic        sda_pin_in,
  output logic        scl_oe,
  output logic        sda_oe,
  output logic        start_det,
  output logic        stop_det,
  output logic        ack_ok,
  output logic        nack,
  output logic        txn_done,
  output logic        txn_ok,
  output logic        busy,
  output logic [7:0]  last_byte,
  output logic [15:0] byte_count,
  output logic [7:0]  nack_count
);

  assign scl_oe = ~scl_in & ~rst;
  assign sda_oe = ~sda_drv & ~rst;

  logic scl_s, sda_s;

  bit_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sda_sync (
    .clk(clk), .rst(rst), .d(sda_pin_in), .q(sda_s)
  );

  bit_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_scl_dly (
    .clk(clk), .rst(rst), .d(scl_in), .q(scl_s)
  );

  logic scl_p_q, sda_p_q;
  logic start_ev, stop_ev, rise_ev;
  logic start_ev_q, stop_ev_q, rise_ev_q;

  assign start_ev = scl_s & scl_p_q & sda_p_q & ~sda_s;
  assign stop_ev  = scl_s & scl_p_q & ~sda_p_q & sda_s;
  assign rise_ev  = scl_s & ~scl_p_q;

  // Events are registered once before the FSM; sda_p_q then holds the SDA value
  // that was present when the registered event was decoded.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_p_q    <= 1'b1;
      sda_p_q    <= 1'b1;
      start_ev_q <= 1'b0;
      stop_ev_q  <= 1'b0;
      rise_ev_q  <= 1'b0;
    end else begin
      scl_p_q    <= scl_s;
      sda_p_q    <= sda_s;
      start_ev_q <= start_ev;
      stop_ev_q  <= stop_ev;
      rise_ev_q  <= rise_ev;
    end
  end

  i2cmon_state_t state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  last_byte_q, last_byte_d;
  logic [15:0] byte_count_q, byte_count_d;
  logic [7:0]  nack_count_q, nack_count_d;
  logic        txn_nack_q, txn_nack_d;
  logic        txn_ok_q, txn_ok_d;
  logic        start_det_q, start_det_d;
  logic        stop_det_q, stop_det_d;
  logic        ack_ok_q, ack_ok_d;
  logic        nack_q, nack_d;
  logic        txn_done_q, txn_done_d;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shreg_d      = shreg_q;
    last_byte_d  = last_byte_q;
    byte_count_d = byte_count_q;
    nack_count_d = nack_count_q;
    txn_nack_d   = txn_nack_q;
    txn_ok_d     = txn_ok_q;
    start_det_d  = 1'b0;
    stop_det_d   = 1'b0;
    ack_ok_d     = 1'b0;
    nack_d       = 1'b0;
    txn_done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_ev_q) begin
          state_d      = ACTIVE;
          bit_cnt_d    = '0;
          byte_count_d = '0;
          txn_nack_d   = 1'b0;
          start_det_d  = 1'b1;
        end else if (stop_ev_q) begin
          stop_det_d = 1'b1;
        end
      end
      ACTIVE: begin
        if (start_ev_q) begin
          bit_cnt_d   = '0;
          start_det_d = 1'b1;
        end else if (stop_ev_q) begin
          state_d    = IDLE;
          stop_det_d = 1'b1;
          txn_done_d = 1'b1;
          txn_ok_d   = ~txn_nack_q & (byte_count_q == N_BYTES) & (bit_cnt_q == '0);
        end else if (rise_ev_q) begin
          if (bit_cnt_q < I2C_ACK_BIT) begin
            shreg_d   = {shreg_q[6:0], sda_p_q};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else begin
            last_byte_d  = shreg_q;
            byte_count_d = byte_count_q + 16'd1;
            bit_cnt_d    = '0;
            if (sda_p_q) begin
              nack_d     = 1'b1;
              txn_nack_d = 1'b1;
              if (nack_count_q != NACK_CNT_MAX) nack_count_d = nack_count_q + 8'd1;
            end else begin
              ack_ok_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shreg_q      <= '0;
      last_byte_q  <= '0;
      byte_count_q <= '0;
      nack_count_q <= '0;
      txn_nack_q   <= 1'b0;
      txn_ok_q     <= 1'b0;
      start_det_q  <= 1'b0;
      stop_det_q   <= 1'b0;
      ack_ok_q     <= 1'b0;
      nack_q       <= 1'b0;
      txn_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      last_byte_q  <= last_byte_d;
      byte_count_q <= byte_count_d;
      nack_count_q <= nack_count_d;
      txn_nack_q   <= txn_nack_d;
      txn_ok_q     <= txn_ok_d;
      start_det_q  <= start_det_d;
      stop_det_q   <= stop_det_d;
      ack_ok_q     <= ack_ok_d;
      nack_q       <= nack_d;
      txn_done_q   <= txn_done_d;
    end
  end

  assign start_det  = start_det_q;
  assign stop_det   = stop_det_q;
  assign ack_ok     = ack_ok_q;
  assign nack       = nack_q;
  assign txn_done   = txn_done_q;
  assign txn_ok     = txn_ok_q;
  assign busy       = (state_q == ACTIVE);
  assign last_byte  = last_byte_q;
  assign byte_count = byte_count_q;
  assign nack_count = nack_count_q;

endmodule

// File: tb/tb_i2c_ack_monitor.sv
// Self-checking bench for i2c_ack_monitor: pin-level I2C stimulus, a transaction-rule
// model updated as the bus is driven, and a per-cycle comparison once the bus settles.
module tb_i2c_ack_monitor;

  localparam int SYNC = 3;
  localparam int P    = 6;
  localparam logic [15:0] NB = 16'h17;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scl_in = 1'b1, sda_drv = 1'b1, sda_pin_in = 1'b1;
  logic scl_oe, sda_oe, start_det, stop_det, ack_ok, nack, txn_done, txn_ok, busy;
  logic [7:0]  last_byte, nack_count;
  logic [15:0] byte_count;

  i2c_ack_monitor #(.N_BYTES(NB), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .scl_in(scl_in), .sda_drv(sda_drv), .sda_pin_in(sda_pin_in),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .start_det(start_det), .stop_det(stop_det),
    .ack_ok(ack_ok), .nack(nack), .txn_done(txn_done), .txn_ok(txn_ok), .busy(busy),
    .last_byte(last_byte), .byte_count(byte_count), .nack_count(nack_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, last_chg = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model of what the bus has carried so far.
  int m_active = 0, m_bits = 0, m_sh = 0, m_bc = 0, m_last = 0, m_nc = 0;
  int m_tnack = 0, m_tok = 0;
  int e_ns = 0, e_np = 0, e_na = 0, e_nn = 0, e_nd = 0;
  int d_ns = 0, d_np = 0, d_na = 0, d_nn = 0, d_nd = 0;
  logic p_scl = 1'b1, p_sda = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic m_start();
    e_ns++;
    if (m_active == 0) begin
      m_active = 1; m_bc = 0; m_tnack = 0;
    end
    m_bits = 0;
  endtask

  task automatic m_stop();
    e_np++;
    if (m_active != 0) begin
      e_nd++;
      m_tok = (m_tnack == 0 && m_bc == int'(NB) && m_bits == 0) ? 1 : 0;
      m_active = 0;
    end
  endtask

  task automatic m_bit(input logic b);
    if (m_active == 0) return;
    if (m_bits < 8) begin
      m_sh = ((m_sh << 1) | int'(b)) & 255;
      m_bits++;
    end else begin
      m_last = m_sh;
      m_bc = (m_bc + 1) % 65536;
      if (b) begin
        e_nn++; m_tnack = 1;
        if (m_nc < 255) m_nc++;
      end else e_na++;
      m_bits = 0;
    end
  endtask

  task automatic m_reset();
    m_active = 0; m_bits = 0; m_sh = 0; m_bc = 0; m_last = 0; m_nc = 0;
    m_tnack = 0; m_tok = 0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_pins(input logic s, input logic d);
    if (p_scl && s) begin
      if (p_sda && !d) m_start();
      else if (!p_sda && d) m_stop();
    end else if (!p_scl && s) m_bit(d);
    scl_in = s; sda_pin_in = d; sda_drv = d;
    p_scl = s; p_sda = d;
    last_chg = cyc;
  endtask

  task automatic send_bit(input logic b);
    set_pins(1'b0, b); wait_cyc(P);
    set_pins(1'b1, b); wait_cyc(P);
  endtask

  task automatic send_bits(input logic [7:0] data, input int n);
    for (int i = 7; i > 7 - n; i--) send_bit(data[i]);
  endtask

  task automatic send_byte(input logic [7:0] data, input logic ackb);
    send_bits(data, 8);
    send_bit(ackb);
  endtask

  task automatic i2c_start();
    set_pins(1'b1, 1'b0); wait_cyc(P);
  endtask

  task automatic i2c_stop();
    if (p_scl && !p_sda) begin
      set_pins(1'b1, 1'b1); wait_cyc(P);
    end else begin
      set_pins(1'b0, 1'b0); wait_cyc(P);
      set_pins(1'b1, 1'b0); wait_cyc(P);
      set_pins(1'b1, 1'b1); wait_cyc(P);
    end
  endtask

  // Pads every cycle; registered outputs and pulse tallies once the bus has settled.
  always @(negedge clk) begin
    chk("scl_oe", 32'(scl_oe), 32'(!scl_in && !rst));
    chk("sda_oe", 32'(sda_oe), 32'(!sda_drv && !rst));
    if (start_det === 1'b1) d_ns++;
    if (stop_det === 1'b1)  d_np++;
    if (ack_ok === 1'b1)    d_na++;
    if (nack === 1'b1)      d_nn++;
    if (txn_done === 1'b1)  d_nd++;
    if (cyc - last_chg >= SYNC + 2) begin
      chk("busy", 32'(busy), 32'(m_active));
      chk("byte_count", 32'(byte_count), m_bc);
      chk("last_byte", 32'(last_byte), m_last);
      chk("nack_count", 32'(nack_count), m_nc);
      chk("txn_ok", 32'(txn_ok), m_tok);
      chk("n_start_det", d_ns, e_ns);
      chk("n_stop_det", d_np, e_np);
      chk("n_ack_ok", d_na, e_na);
      chk("n_nack", d_nn, e_nn);
      chk("n_txn_done", d_nd, e_nd);
    end
  end

  int ack0, stop0, done0;

  initial begin
    wait_cyc(4);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_byte_count", 32'(byte_count), 0);
    chk("rst_nack_count", 32'(nack_count), 0);
    chk("rst_txn_ok", 32'(txn_ok), 0);
    rst = 1'b0; last_chg = cyc;
    wait_cyc(P);

    sda_drv = 1'b0; #1;
    chk("pad_sda_oe_comb", 32'(sda_oe), 1);
    chk("pad_scl_oe_high", 32'(scl_oe), 0);
    sda_drv = 1'b1; #1;
    chk("pad_sda_oe_rel", 32'(sda_oe), 0);
    wait_cyc(1);

    // START latency: pulse after edge n+SYNC+1 where edge n first samples the fall.
    set_pins(1'b1, 1'b0);
    @(posedge clk);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("start_latency", 32'(start_det), 32'(k == SYNC + 1));
      if (k < 5) @(posedge clk);
    end
    wait_cyc(1);

    // Good transaction continues from the START above.
    ack0 = d_na;
    send_byte(8'h20, 1'b0);
    for (int i = 1; i < int'(NB); i++) send_byte(8'((i * 37 + 5) & 255), 1'b0);
    i2c_stop();
    chk("good_byte_count", 32'(byte_count), 32'h17);
    chk("good_txn_ok", 32'(txn_ok), 1);
    chk("good_nack_count", 32'(nack_count), 0);
    chk("good_acks", d_na - ack0, 32'h17);

    i2c_start(); send_byte(8'h20, 1'b1); i2c_stop();
    chk("nack_count_1", 32'(nack_count), 1);
    chk("nack_txn_ok", 32'(txn_ok), 0);
    chk("nack_last_byte", 32'(last_byte), 32'h20);

    i2c_start();
    for (int i = 0; i < 5; i++) send_byte(8'(8'hA0 + i), 1'b0);
    i2c_stop();
    chk("short_byte_count", 32'(byte_count), 5);
    chk("short_txn_ok", 32'(txn_ok), 0);

    i2c_start(); send_bits(8'h17, 3); i2c_stop();
    chk("midbyte_txn_ok", 32'(txn_ok), 0);
    chk("midbyte_byte_count", 32'(byte_count), 0);

    stop0 = d_np; done0 = d_nd;
    i2c_stop();
    chk("idle_stop_det", d_np - stop0, 1);
    chk("idle_no_done", d_nd - done0, 0);

    i2c_start(); send_byte(8'h5A, 1'b0); send_bits(8'hC3, 4);
    set_pins(1'b0, 1'b0); wait_cyc(P);
    done0 = d_nd;
    rst = 1'b1; m_reset(); last_chg = cyc;
    wait_cyc(3);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_byte_count", 32'(byte_count), 0);
    chk("rst_mid_nack_count", 32'(nack_count), 0);
    chk("rst_mid_last_byte", 32'(last_byte), 0);
    chk("rst_mid_scl_oe", 32'(scl_oe), 0);
    chk("rst_mid_sda_oe", 32'(sda_oe), 0);
    rst = 1'b0; last_chg = cyc;
    wait_cyc(P);
    i2c_stop();
    chk("rst_mid_no_done", d_nd - done0, 0);

    for (int t = 0; t < 300; t++) begin
      i2c_start(); send_byte(8'h20, 1'b1); i2c_stop();
    end
    chk("nack_saturate", 32'(nack_count), 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
